// File: rtl/gpu_cmd_arb.sv
// gpu_cmd_arb: packet-granular round-robin arbiter merging N_CH command
// streams onto a single GPU command port. A channel keeps the grant from
// its first word until the word carrying in_last has been accepted.
//
// Build option GPU_CMD_ARB_SKID_EN: when defined, the output path is a
// 2-entry registered skid buffer; when undefined, the granted channel is
// passed straight through to the output with zero latency.
module gpu_cmd_arb #(
  parameter int N_CH = 2,
  parameter int DW   = 64,
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_last,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [CW-1:0]      out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  state_e        state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] rr_pick;
  logic          rr_found;

  logic          g_valid;
  logic          g_ready;
  logic          g_fire;
  beat_t         g_beat;

  // Arbitration state: IDLE/LOCK, current grant and the channel served last.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would create ordering races.
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(N_CH - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Round-robin search: first requesting channel after last_grant, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!rr_found && in_valid[(int'(last_grant_q) + i) % N_CH]) begin
        rr_pick  = CW'((int'(last_grant_q) + i) % N_CH);
        rr_found = 1'b1;
      end
    end
  end

  // Select the granted channel's word and flags.
  always_comb begin
    g_valid = 1'b0;
    g_beat  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (CW'(k) == grant_q) begin
        g_valid     = in_valid[k];
        g_beat.data = in_data[k*DW +: DW];
        g_beat.last = in_last[k];
      end
    end
    g_beat.chan = grant_q;
  end

  assign g_fire = g_valid && g_ready;

  // Next-state: grab a channel in IDLE, release on the accepted last word.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = rr_pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (g_fire && g_beat.last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted channel may ever see ready.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (CW'(k) == grant_q) in_ready[k] = g_ready;
    end
  end

`ifdef GPU_CMD_ARB_SKID_EN

  beat_t out_q, skid_q;
  logic  out_v_q, skid_v_q;
  logic  pop;

  // Ready comes only from local state, never from out_ready.
  assign g_ready = (state_q == LOCK) && !skid_v_q;
  assign pop     = out_v_q && out_ready;

  // Two-entry buffer: out_q is the head shown on the port, skid_q catches
  // the word accepted while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset too, because the outputs must read
    // zero during reset, not just be marked invalid.
    if (!rst_n) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (pop) begin
      if (skid_v_q) begin
        out_q    <= skid_q;
        skid_v_q <= g_fire;
        if (g_fire) skid_q <= g_beat;
      end else begin
        out_v_q <= g_fire;
        if (g_fire) out_q <= g_beat;
      end
    end else if (!out_v_q) begin
      out_v_q <= g_fire;
      if (g_fire) out_q <= g_beat;
    end else if (g_fire) begin
      skid_v_q <= 1'b1;
      skid_q   <= g_beat;
    end
  end

  assign out_valid = out_v_q;
  assign out_data  = out_q.data;
  assign out_last  = out_q.last;
  assign out_chan  = out_q.chan;

`else

  assign g_ready = (state_q == LOCK) && out_ready;

  // Pass-through of the granted channel while locked; quiet otherwise.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_chan  = '0;
    if (state_q == LOCK) begin
      out_valid = g_valid;
      out_data  = g_beat.data;
      out_last  = g_beat.last;
      out_chan  = g_beat.chan;
    end
  end

`endif

endmodule

// File: tb/tb_gpu_cmd_arb.sv
// Self-checking bench for gpu_cmd_arb: a 4-channel instance driven from
// per-channel packet queues and checked by a scoreboard, plus a 1-channel
// instance for the degenerate case. Expected output order comes from a
// packet-level round-robin model over channels with pending packets.
module tb_gpu_cmd_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 2;
  localparam int DW1 = 16;
`ifdef GPU_CMD_ARB_SKID_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    logic          last;
    logic [DW1-1:0] data;
  } exp1_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last, in_valid, in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last, out_valid, out_ready;
  logic [CW-1:0]   out_chan;

  logic [DW1-1:0]  in1_data, out1_data;
  logic            in1_last, in1_valid, in1_ready;
  logic            out1_last, out1_valid, out1_ready;
  logic            out1_chan;

  gpu_cmd_arb #(.N_CH(N), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  gpu_cmd_arb #(.N_CH(1), .DW(DW1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in1_data), .in_last(in1_last), .in_valid(in1_valid), .in_ready(in1_ready),
    .out_data(out1_data), .out_last(out1_last), .out_chan(out1_chan),
    .out_valid(out1_valid), .out_ready(out1_ready)
  );

  word_t     chq[N][$];
  exp_t      exp_q[$];
  exp1_t     exp1_q[$];
  int        t1_q[$];
  logic [N-1:0] hold = '0;
  int        model_last = N - 1;
  int        n_pass = 0;
  int        n_checks = 0;
  int        cyc = 0;
  bit        rnd_ready = 1'b0;
  bit        bubble_chk = 1'b0;
  bit        prev_last_fire = 1'b0;
  logic [N-1:0] fire;
`ifdef GPU_CMD_ARB_SKID_EN
  logic [N-1:0] rdy_snap;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Append one packet of len random words to channel k's source queue.
  task automatic gen_pkt(input int k, input int len);
    word_t w;
    for (int j = 0; j < len; j++) begin
      w.data = $urandom;
      w.last = (j == len - 1);
      chq[k].push_back(w);
    end
  endtask

  // Reference model: whole packets, round-robin over channels that still
  // hold packets, starting after the channel served last.
  task automatic plan_batch();
    word_t mq[N][$];
    word_t w;
    int    pick;
    for (int k = 0; k < N; k++) mq[k] = chq[k];
    forever begin
      pick = -1;
      for (int i = 1; i <= N; i++)
        if (pick < 0 && mq[(model_last + i) % N].size() > 0) pick = (model_last + i) % N;
      if (pick < 0) break;
      do begin
        w = mq[pick].pop_front();
        exp_q.push_back({CW'(pick), w.last, w.data});
      end while (!w.last);
      model_last = pick;
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) chq[k].delete();
    exp_q.delete();
    hold = '0;
    model_last = N - 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({name, " drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Source driver: offer each channel's queue head, retire it on handshake.
  always begin
    @(negedge clk);
    fire = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (fire[k] && chq[k].size() > 0) void'(chq[k].pop_front());
    for (int k = 0; k < N; k++) begin
      in_valid[k] = !hold[k] && (chq[k].size() > 0);
      if (chq[k].size() > 0) begin
        in_data[k*DW +: DW] = chq[k][0].data;
        in_last[k]          = chq[k][0].last;
      end else begin
        in_data[k*DW +: DW] = '0;
        in_last[k]          = 1'b0;
      end
    end
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef GPU_CMD_ARB_SKID_EN
    if (rnd_ready && rst_n) begin
      rdy_snap  = in_ready;
      out_ready = ~out_ready;
      #1;
      check("in_ready independent of out_ready", 64'(in_ready), 64'(rdy_snap));
      out_ready = ~out_ready;
    end
`endif
  end

  // Scoreboard monitor for the 4-channel instance.
  always @(negedge clk) begin
    exp_t e;
    if (bubble_chk && prev_last_fire) check("bubble after packet", 64'(out_valid), 64'd0);
    prev_last_fire = out_valid && out_ready && out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious word: got chan %0d last %0d data %h, none expected",
                 out_chan, out_last, out_data);
      end else begin
        e = exp_q.pop_front();
        check("output word {chan,last,data}", 64'({out_chan, out_last, out_data}), 64'(e));
      end
    end
  end

  // Scoreboard monitor for the 1-channel instance.
  always @(negedge clk) begin
    exp1_t e;
    if (out1_valid && out1_ready) begin
      t1_q.push_back(cyc);
      if (exp1_q.size() == 0) begin
        n_checks++;
        $display("FAIL n1 spurious word: got data %h", out1_data);
      end else begin
        e = exp1_q.pop_front();
        check("n1 word {chan,last,data}", 64'({out1_chan, out1_last, out1_data}), 64'({1'b0, e}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int idx;
    logic [DW1-1:0] w1[2];

    in_data = '0; in_last = '0; in_valid = '0; out_ready = 1'b1;
    in1_data = '0; in1_last = 1'b0; in1_valid = 1'b0; out1_ready = 1'b1;

    // Reset values with a request already pending on ch0.
    rst_n = 1'b0;
    gen_pkt(0, 2);
    repeat (2) @(posedge clk);
    #3;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_chan/last", 64'({out_chan, out_last}), 64'd0);
    check("reset n1 out_valid/in_ready", 64'({out1_valid, in1_ready}), 64'd0);
    clear_all();

    // Single 3-word packet on ch0, latency to first output word.
    do_reset();
    bubble_chk = 1'b1;
    gen_pkt(0, 3);
    plan_batch();
    @(posedge clk);
    #2 t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("first word latency", 64'(cyc - t0), 64'(LAT));
    drain("single packet", 100);

    // ch0 and ch1 with two 2-word packets each: alternate, one bubble apart.
    do_reset();
    gen_pkt(0, 2); gen_pkt(0, 2);
    gen_pkt(1, 2); gen_pkt(1, 2);
    plan_batch();
    drain("alternating packets", 200);

    // ch1 locked, valid dropped mid-packet while ch0 waits.
    do_reset();
    gen_pkt(1, 5);
    foreach (chq[1][j]) exp_q.push_back({CW'(1), chq[1][j].last, chq[1][j].data});
    repeat (2) @(posedge clk);
    #2;
    gen_pkt(0, 3);
    foreach (chq[0][j]) exp_q.push_back({CW'(0), chq[0][j].last, chq[0][j].data});
    for (int i = 0; i < 50 && chq[1].size() > 3; i++) begin
      @(posedge clk);
      #2;
    end
    hold[1] = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("ch0 ready while ch1 holds lock", 64'(in_ready[0]), 64'd0);
    end
    hold[1] = 1'b0;
    drain("held packet", 200);

    // Asynchronous reset in the middle of a ch1 packet.
    do_reset();
    gen_pkt(1, 6);
    plan_batch();
    for (int i = 0; i < 50 && exp_q.size() > 4; i++) begin
      @(posedge clk);
      #2;
    end
    #1 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_data", 64'(out_data), 64'd0);
    check("async reset out_chan/last", 64'({out_chan, out_last}), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd0);
    clear_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    gen_pkt(1, 2);
    gen_pkt(0, 2);
    plan_batch();
    drain("post-reset arbitration", 200);

    // Random packet lengths, all four channels, out_ready toggling.
    do_reset();
    bubble_chk = 1'b0;
    rnd_ready = 1'b1;
    for (int p = 0; p < 25; p++)
      for (int k = 0; k < N; k++) gen_pkt(k, $urandom_range(1, 8));
    plan_batch();
    drain("random traffic", 20000);
    rnd_ready = 1'b0;

    // Single-channel instance: two one-word packets with one bubble between.
    do_reset();
    w1[0] = 16'h1234;
    w1[1] = 16'hABCD;
    exp1_q.push_back({1'b1, w1[0]});
    exp1_q.push_back({1'b1, w1[1]});
    idx = 0;
    for (int i = 0; i < 40 && idx < 2; i++) begin
      @(posedge clk);
      #1;
      in1_valid = 1'b1;
      in1_data  = w1[idx];
      in1_last  = 1'b1;
      @(negedge clk);
      if (in1_valid && in1_ready) idx++;
    end
    @(posedge clk);
    #1 in1_valid = 1'b0;
    repeat (6) @(posedge clk);
    check("n1 drained", 64'(exp1_q.size()), 64'd0);
    if (t1_q.size() == 2) check("n1 cycles between packets", 64'(t1_q[1] - t1_q[0]), 64'd2);
    else check("n1 word count", 64'(t1_q.size()), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
